// File: rtl/systolic_tile_scheduler_if.sv
// Job, array-control and tile-buffer signals of the systolic tile scheduler.
// The scheduler uses the slave modport; the host/array side uses master.
interface systolic_tile_scheduler_if #(
  parameter int SIZE = 4,
  parameter int DIMW = 8
);
  localparam int TW = $clog2(SIZE) + 1;

  logic            cfg_valid;
  logic            cfg_ready;
  logic [DIMW-1:0] cfg_m;
  logic [DIMW-1:0] cfg_k;
  logic [DIMW-1:0] cfg_n;
  logic            arr_start;
  logic            arr_done;
  logic [TW-1:0]   depth_A;
  logic [TW-1:0]   width_A;
  logic [TW-1:0]   depth_B;
  logic [TW-1:0]   width_B;
  logic [DIMW-1:0] tile_row;
  logic [DIMW-1:0] tile_col;
  logic [DIMW-1:0] tile_k;
  logic            acc_first;
  logic            tile_valid;
  logic            job_done;
  logic            busy;
  logic            err;

  modport slave (
    input  cfg_valid, cfg_m, cfg_k, cfg_n, arr_done,
    output cfg_ready, arr_start, depth_A, width_A, depth_B, width_B,
           tile_row, tile_col, tile_k, acc_first, tile_valid, job_done, busy, err
  );

  modport master (
    output cfg_valid, cfg_m, cfg_k, cfg_n, arr_done,
    input  cfg_ready, arr_start, depth_A, width_A, depth_B, width_B,
           tile_row, tile_col, tile_k, acc_first, tile_valid, job_done, busy, err
  );
endinterface

// File: rtl/systolic_tile_scheduler.sv
// Walks an MxK * KxN product as SIZE-square output tiles and SIZE-wide K chunks.
// Define SCHED_TIMEOUT_EN to abort a job whose array done does not arrive in TIMEOUT cycles.
module systolic_tile_scheduler #(
  parameter int SIZE    = 4,
  parameter int DIMW    = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  systolic_tile_scheduler_if.slave bus
);
  localparam int            TW     = $clog2(SIZE) + 1;
  localparam logic [DIMW:0] SIZE_X = (DIMW + 1)'(SIZE);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, STORE, NEXT, DONE} state_t;

  state_t          state_reg;
  logic            cfg_ready_reg;
  logic            arr_start_reg;
  logic            acc_first_reg;
  logic            tile_valid_reg;
  logic            job_done_reg;
  logic            busy_reg;
  logic            err_reg;
  // Index 0: M / tile_row, 1: K / tile_k, 2: N / tile_col
  logic [DIMW-1:0] dim_reg [3];
  logic [DIMW-1:0] off_reg [3];
  logic [DIMW:0]   sum [3];
  logic [TW-1:0]   len [3];
  logic [2:0]      wrap;
  logic            dim_zero;

`ifdef SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt_reg;
`endif

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dim
      logic [DIMW:0] rem;
      assign rem      = {1'b0, dim_reg[gi]} - {1'b0, off_reg[gi]};
      assign len[gi]  = (rem >= SIZE_X) ? TW'(SIZE) : rem[TW-1:0];
      assign sum[gi]  = {1'b0, off_reg[gi]} + SIZE_X;
      assign wrap[gi] = (sum[gi] >= {1'b0, dim_reg[gi]});
    end
  endgenerate

  assign dim_zero = (bus.cfg_m == '0) || (bus.cfg_k == '0) || (bus.cfg_n == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      cfg_ready_reg  <= 1'b1;
      arr_start_reg  <= 1'b0;
      acc_first_reg  <= 1'b0;
      tile_valid_reg <= 1'b0;
      job_done_reg   <= 1'b0;
      busy_reg       <= 1'b0;
      err_reg        <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        dim_reg[i] <= '0;
        off_reg[i] <= '0;
      end
`ifdef SCHED_TIMEOUT_EN
      wait_cnt_reg <= '0;
`endif
    end else begin
      arr_start_reg  <= 1'b0;
      tile_valid_reg <= 1'b0;
      job_done_reg   <= 1'b0;
      err_reg        <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.cfg_valid && cfg_ready_reg) begin
            dim_reg[0]    <= bus.cfg_m;
            dim_reg[1]    <= bus.cfg_k;
            dim_reg[2]    <= bus.cfg_n;
            for (int i = 0; i < 3; i++) off_reg[i] <= '0;
            cfg_ready_reg <= 1'b0;
            busy_reg      <= 1'b1;
            if (dim_zero) begin
              err_reg       <= 1'b1;
              job_done_reg  <= 1'b1;
              acc_first_reg <= 1'b0;
              state_reg     <= DONE;
            end else begin
              arr_start_reg <= 1'b1;
              acc_first_reg <= 1'b1;
              state_reg     <= ISSUE;
            end
          end
        end
        ISSUE: begin
`ifdef SCHED_TIMEOUT_EN
          wait_cnt_reg <= '0;
`endif
          state_reg <= WAIT;
        end
        WAIT: begin
          if (bus.arr_done) begin
            tile_valid_reg <= wrap[1];
            state_reg      <= STORE;
          end
`ifdef SCHED_TIMEOUT_EN
          else if (wait_cnt_reg == CW'(TIMEOUT - 1)) begin
            err_reg      <= 1'b1;
            job_done_reg <= 1'b1;
            state_reg    <= DONE;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + CW'(1);
          end
`endif
        end
        STORE: state_reg <= NEXT;
        NEXT: begin
          // k is innermost, then col, then row
          if (!wrap[1]) begin
            off_reg[1]    <= sum[1][DIMW-1:0];
            acc_first_reg <= 1'b0;
            arr_start_reg <= 1'b1;
            state_reg     <= ISSUE;
          end else if (!wrap[2]) begin
            off_reg[1]    <= '0;
            off_reg[2]    <= sum[2][DIMW-1:0];
            acc_first_reg <= 1'b1;
            arr_start_reg <= 1'b1;
            state_reg     <= ISSUE;
          end else if (!wrap[0]) begin
            off_reg[1]    <= '0;
            off_reg[2]    <= '0;
            off_reg[0]    <= sum[0][DIMW-1:0];
            acc_first_reg <= 1'b1;
            arr_start_reg <= 1'b1;
            state_reg     <= ISSUE;
          end else begin
            for (int i = 0; i < 3; i++) off_reg[i] <= '0;
            job_done_reg <= 1'b1;
            state_reg    <= DONE;
          end
        end
        DONE: begin
          cfg_ready_reg <= 1'b1;
          busy_reg      <= 1'b0;
          acc_first_reg <= 1'b0;
          state_reg     <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.cfg_ready  = cfg_ready_reg;
  assign bus.arr_start  = arr_start_reg;
  assign bus.depth_A    = len[0];
  assign bus.width_A    = len[1];
  assign bus.depth_B    = len[1];
  assign bus.width_B    = len[2];
  assign bus.tile_row   = off_reg[0];
  assign bus.tile_k     = off_reg[1];
  assign bus.tile_col   = off_reg[2];
  assign bus.acc_first  = acc_first_reg;
  assign bus.tile_valid = tile_valid_reg;
  assign bus.job_done   = job_done_reg;
  assign bus.busy       = busy_reg;
  assign bus.err        = err_reg;
endmodule

// File: doc/systolic_tile_scheduler.md
Name: systolic_tile_scheduler

Overview:
Sequences the 4x4 systolic array accelerator over an arbitrary MxK * KxN matrix product by splitting it into SIZE x SIZE output tiles and SIZE-wide K chunks. For each chunk it drives the per-tile dimensions and a start pulse, then waits for the array's done. It tells the downstream tile buffer whether to overwrite or accumulate each chunk and when an output tile is final. It sits between the host job interface and the accelerator top.

Parameters:
SIZE, 4, array dimension; tile edge length.
DIMW, 8, width of the job dimensions and tile offsets; max dimension 2^DIMW-1.
TIMEOUT, 64, done-wait limit in cycles; used only when SCHED_TIMEOUT_EN is defined.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous active-low reset.
cfg_valid  input  1  job request.
cfg_ready  output  1  scheduler can accept a job; high only in IDLE.
cfg_m  input  DIMW  rows of A.
cfg_k  input  DIMW  columns of A, which equal the rows of B.
cfg_n  input  DIMW  columns of B.
arr_start  output  1  one-cycle start pulse to the array.
arr_done  input  1  array completion pulse.
depth_A, width_A, depth_B, width_B  output  $clog2(SIZE)+1 each  tile dimensions to the array.
tile_row, tile_col, tile_k  output  DIMW each  base offsets of the current tile or chunk.
acc_first  output  1  current chunk is the first K chunk; the buffer overwrites instead of adding.
tile_valid  output  1  one-cycle pulse: the output tile at tile_row/tile_col is complete.
job_done  output  1  one-cycle pulse at the end of the job.
busy  output  1  high in every state except IDLE.
err  output  1  one-cycle error pulse.

Behaviour:
- Reset while reset=0, asynchronous and allowed mid-operation:
  - state goes to IDLE.
  - all outputs are 0 except cfg_ready=1.
  - all counters are 0.
  - no pending pulse survives reset.
- States: IDLE, ISSUE, WAIT, STORE, NEXT, DONE.
- IDLE:
  - A job is accepted on the cycle where cfg_valid and cfg_ready are both high; cfg_m/k/n are latched on that cycle.
  - If any dimension is 0, go to DONE with err=1, and job_done pulses in the same cycle. No arr_start is issued.
  - Otherwise tile_row=tile_col=tile_k=0 and the next state is ISSUE.
- ISSUE: arr_start=1 for exactly one cycle, then WAIT. Tile fields are computed as:
  - depth_A = min(SIZE, M - tile_row)
  - width_A = depth_B = min(SIZE, K - tile_k)
  - width_B = min(SIZE, N - tile_col)
  - acc_first = (tile_k == 0)
  - All of these are stable from ISSUE until STORE completes.
- WAIT: hold until arr_done=1, then STORE. arr_done in any other state is ignored.
- STORE: for one cycle, tile_valid=1 if tile_k + SIZE >= K (last chunk), else 0. Next state is NEXT.
- NEXT: advance the counters with k innermost, then col, then row. Each counter advances by SIZE and wraps to 0 once it reaches or passes its dimension.
  - If all three counters wrap, go to DONE.
  - Otherwise go to ISSUE.
- DONE: job_done=1 for one cycle, then IDLE.
- Timing:
  - Accept at cycle T gives arr_start at T+1.
  - arr_done at cycle D gives STORE at D+1, NEXT at D+2, and either the next arr_start at D+3 or job_done at D+3.
- Array operations per job: ceil(M/S)*ceil(N/S)*ceil(K/S). tile_valid pulses ceil(M/S)*ceil(N/S) times.
- Arithmetic: counter compares are done at DIMW+1 bits so that offset + SIZE cannot overflow. The min() results always lie in 1..SIZE.
- cfg_valid while busy: ignored. The job is not lost; it is accepted once back in IDLE if still asserted.
- arr_done in the same cycle as arr_start: ignored, because the scheduler is not yet in WAIT.

Optional Feature:
SCHED_TIMEOUT_EN
- Defined:
  - A wait counter is cleared on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT without arr_done, err pulses and the job aborts to DONE (job_done pulses). No tile_valid is issued for the aborted tile.
- Not defined: no counter exists; WAIT is unbounded and err fires only for zero dimensions.

Test Plan:
- M=K=N=4, arr_done 10 cycles after arr_start:
  - exactly 1 arr_start, with dims 4/4/4/4 and acc_first=1.
  - tile_valid at D+1, job_done at D+3.
- M=6, K=5, N=7:
  - 8 arr_starts, 4 tile_valid pulses.
  - last chunk has depth_A=2, width_A=1, width_B=3, acc_first=0, tile_row=4, tile_col=4, tile_k=4.
- cfg_n=0: no arr_start; err and job_done pulse together one cycle after accept; cfg_ready returns next cycle.
- Reset asserted during WAIT of the 3rd chunk of M=K=N=8:
  - all outputs 0 immediately, cfg_ready=1.
  - a new 4x4x4 job afterwards completes normally.
- cfg_valid held during a job, plus a spurious arr_done pulse in ISSUE/STORE:
  - the second job is accepted only after job_done.
  - spurious pulses cause no state change.
- With SCHED_TIMEOUT_EN and TIMEOUT=64, arr_done never asserted: err and job_done pulse 64 cycles after entering WAIT, and there is no tile_valid.
